// File: rtl/axi_dma_read_sequencer_pkg.sv
// axi_dma_pkg: shared FSM state, AXI response codes and AR constants for the DMA read sequencer.
package axi_dma_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [3:0] ARCACHE = 4'b0011;
  localparam logic [2:0] ARPROT = 3'b000;
  function automatic int BYTES_PER_BEAT(int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/axi_dma_read_sequencer_if.sv
// axi_dma_read_sequencer_if: AXI AR/R channels plus the outgoing word stream.
interface axi_dma_read_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master (
    output araddr, arlen, arsize, arcache, arprot, arvalid, rready, m_data, m_valid,
    input arready, rdata, rresp, rlast, rvalid, m_ready
  );
  modport slave (
    input araddr, arlen, arsize, arcache, arprot, arvalid, rready, m_data, m_valid,
    output arready, rdata, rresp, rlast, rvalid, m_ready
  );
endinterface

// File: rtl/axi_dma_read_sequencer_burst_calc.sv
// axi_dma_burst_calc: arlen = min(remaining, MAX_BURST, words to next 4 KB boundary) - 1.
module axi_dma_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_WIDTH = 24
) (
  input logic [11:0] addr_lo,
  input logic [LEN_WIDTH-1:0] remaining,
  output logic [7:0] arlen
);
  localparam int SHIFT = $clog2(BYTES_PER_BEAT(DATA_WIDTH));
  logic [31:0] to_4k, rem, lim, beats;
  always_comb begin
    to_4k = 32'(13'h1000 - {1'b0, addr_lo}) >> SHIFT;
    rem = 32'(remaining);
    lim = rem < to_4k ? rem : to_4k;
    beats = lim < 32'(MAX_BURST) ? lim : 32'(MAX_BURST);
    arlen = 8'(beats - 32'd1);
  end
endmodule

// File: rtl/axi_dma_read_sequencer.sv
// axi_dma_read_sequencer: splits a word-count read into 4 KB-safe AXI bursts and streams the data out.
module axi_dma_read_sequencer
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_WIDTH = 24
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [ADDR_WIDTH-1:0] cfg_addr,
  input logic [LEN_WIDTH-1:0] cfg_len,
  output logic busy,
  output logic done,
  output logic error,
  axi_dma_read_sequencer_if.master bus
);
  localparam int BPB = BYTES_PER_BEAT(DATA_WIDTH);
  state_t state;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr, ar_addr;
  logic [LEN_WIDTH-1:0] remaining, nxt_rem;
  logic [7:0] beat_cnt, ar_len, calc_arlen;
  logic ar_valid, r_hs, last, beat_err;
  // Burst sizing always looks at the address/count the next burst would start from.
  always_comb begin
    nxt_addr = state == IDLE ? cfg_addr & ~ADDR_WIDTH'(BPB - 1) : addr + ADDR_WIDTH'(BPB);
    nxt_rem = state == IDLE ? cfg_len : remaining - LEN_WIDTH'(1);
    r_hs = state == DATA && bus.rvalid && bus.m_ready;
    last = beat_cnt == 8'd0;
    beat_err = bus.rresp == AXI_RESP_SLVERR || bus.rresp == AXI_RESP_DECERR || bus.rlast != last;
  end
  axi_dma_burst_calc #(.DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .LEN_WIDTH(LEN_WIDTH)) u_calc (
    .addr_lo(nxt_addr[11:0]),
    .remaining(nxt_rem),
    .arlen(calc_arlen)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      ar_valid <= 1'b0;
      ar_addr <= '0;
      ar_len <= '0;
      addr <= '0;
      remaining <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          error <= 1'b0;
          busy <= 1'b1;
          addr <= nxt_addr;
          remaining <= cfg_len;
          if (cfg_len != '0) begin
            state <= ADDR;
            ar_valid <= 1'b1;
            ar_addr <= nxt_addr;
            ar_len <= calc_arlen;
          end else begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        ADDR: if (bus.arready) begin
          ar_valid <= 1'b0;
          beat_cnt <= ar_len;
          state <= DATA;
        end
        DATA: if (r_hs) begin
          addr <= nxt_addr;
          remaining <= nxt_rem;
          beat_cnt <= beat_cnt - 8'd1;
          if (beat_err) error <= 1'b1;
          // The burst always drains; only its final beat decides whether another follows.
          if (last) begin
            if (nxt_rem != '0 && !error && !beat_err) begin
              state <= ADDR;
              ar_valid <= 1'b1;
              ar_addr <= nxt_addr;
              ar_len <= calc_arlen;
            end else begin
              state <= DONE;
              done <= 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.araddr = ar_addr;
  assign bus.arlen = ar_len;
  assign bus.arsize = 3'($clog2(BPB));
  assign bus.arcache = ARCACHE;
  assign bus.arprot = ARPROT;
  assign bus.arvalid = ar_valid;
  assign bus.rready = state == DATA && bus.m_ready;
  assign bus.m_data = bus.rdata;
  assign bus.m_valid = state == DATA && bus.rvalid;
endmodule

// File: tb/tb_axi_dma_read_sequencer.sv
// tb_axi_dma_read_sequencer: randomized AXI slave/consumer against a burst-splitting reference model.
module tb_axi_dma_read_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [23:0] cfg_len = '0;
  logic busy, done, error;
  int n_tests = 0;
  int n_fail = 0;
  axi_dma_read_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
  axi_dma_read_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .LEN_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Slave/consumer behaviour knobs and observations
  int err_beat = -1, last_beat = -1, ar_delay = 0, gbeat = 0, done_cnt = 0;
  bit mready_rand = 0;
  logic [39:0] obs_ar[$];
  logic [31:0] obs_w[$];

  initial begin
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rresp = 2'b00;
    bus.rlast = 1'b0;
    bus.m_ready = 1'b0;
  end

  always begin : slave
    logic [31:0] s_addr, prev_addr;
    logic [7:0] prev_len;
    int s_left, ar_cnt;
    bit ar_prev, hold;
    logic arready_n, rvalid_n, rlast_n, mready_n;
    logic [31:0] rdata_n;
    logic [1:0] rresp_n;
    s_left = 0; ar_cnt = 0; ar_prev = 0;
    forever begin
      @(negedge clk);
      hold = 0;
      if (reset) begin
        s_left = 0; ar_cnt = 0; ar_prev = 0;
      end else begin
        if (bus.arvalid && ar_prev) check("ar_stable", {bus.araddr, bus.arlen}, {prev_addr, prev_len});
        ar_prev = bus.arvalid && !bus.arready;
        prev_addr = bus.araddr;
        prev_len = bus.arlen;
        if (bus.rvalid) check("rready_eq_mready", 64'(bus.rready), 64'(bus.m_ready));
        if (bus.m_valid && bus.m_ready) obs_w.push_back(bus.m_data);
        if (bus.rvalid && bus.rready) begin
          s_addr += 4; s_left--; gbeat++;
        end else if (bus.rvalid) hold = 1;
        if (bus.arvalid && bus.arready) begin
          obs_ar.push_back({bus.araddr, bus.arlen});
          s_addr = bus.araddr; s_left = int'(bus.arlen) + 1; ar_cnt = 0;
        end else if (bus.arvalid) ar_cnt++;
        if (done) done_cnt++;
      end
      arready_n = !reset && ar_cnt >= ar_delay;
      mready_n = mready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid_n = hold ? 1'b1 : s_left > 0 && $urandom_range(0, 3) != 0;
      rdata_n = word_of(s_addr);
      rresp_n = gbeat == err_beat ? 2'b10 : 2'b00;
      rlast_n = (s_left == 1) ^ (gbeat == last_beat);
      @(posedge clk);
      #1;
      bus.arready = arready_n;
      bus.m_ready = mready_n;
      if (!hold) begin
        bus.rvalid = rvalid_n;
        bus.rdata = rdata_n;
        bus.rresp = rresp_n;
        bus.rlast = rlast_n;
      end
    end
  end

  task automatic run(input logic [31:0] a, input int len, input int eb, input int lb,
                     input bit mr, input int ard, input bit poke);
    logic [39:0] exp_ar[$];
    logic [31:0] exp_w[$];
    logic [31:0] cur;
    int rem, w, b, first, k;
    bit got, busy_ok;
    cur = a & ~32'd3; rem = len; w = 0;
    first = (eb >= 0 && eb < len) ? eb : len;
    if (lb >= 0 && lb < len && lb < first) first = lb;
    // Model: split at MAX_BURST and 4 KB; stop after the burst holding the first bad beat.
    while (rem > 0) begin
      b = (4096 - int'(cur[11:0])) / 4;
      if (b > 16) b = 16;
      if (b > rem) b = rem;
      exp_ar.push_back({cur, 8'(b - 1)});
      for (int j = 0; j < b; j++) exp_w.push_back(word_of(cur + 32'(4 * j)));
      cur += 32'(4 * b); rem -= b; w += b;
      if (w > first) break;
    end
    err_beat = eb; last_beat = lb; mready_rand = mr; ar_delay = ard;
    obs_ar.delete(); obs_w.delete(); done_cnt = 0; gbeat = 0;
    @(posedge clk); #1;
    cfg_addr = a; cfg_len = 24'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; got = 0; busy_ok = 1;
    while (!got && k < 3000) begin
      @(negedge clk);
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
      if (poke && !got && k == 3) begin
        start = 1'b1; cfg_addr = $urandom; cfg_len = 24'($urandom_range(1, 50));
      end
      if (k == 4) start = 1'b0;
      k++;
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("busy_until_done", 64'(busy_ok), 64'd1);
    if (len == 0) check("zero_len_latency", 64'(k), 64'd1);
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("arvalid_after", 64'(bus.arvalid), 64'd0);
    check("error", 64'(error), 64'(first < len));
    check("ar_count", 64'(obs_ar.size()), 64'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < obs_ar.size(); i++) check("ar_addr_len", 64'(obs_ar[i]), 64'(exp_ar[i]));
    check("word_count", 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) check("word", 64'(obs_w[i]), 64'(exp_w[i]));
  endtask

  initial begin
    bit seen;
    logic [31:0] a;
    int len, eb, lb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, error, bus.arvalid, bus.rready, bus.m_valid}, 64'd0);
    check("reset_araddr_arlen", {bus.araddr, bus.arlen}, 64'd0);
    check("arsize_const", 64'(bus.arsize), 64'd2);
    check("arcache_arprot", {bus.arcache, bus.arprot}, {4'b0011, 3'b000});
    @(posedge clk); #1;
    reset = 1'b0;
    run(32'h1000, 16, -1, -1, 0, 0, 0);
    run(32'h0FF8, 8, -1, -1, 0, 0, 0);
    run(32'h2000, 40, -1, -1, 0, 0, 1);
    run(32'h3000, 40, -1, -1, 1, 5, 0);
    run(32'h2000, 40, 2, -1, 1, 0, 0);
    run(32'h4000, 20, -1, 5, 1, 1, 0);
    run(32'h5000, 20, -1, 15, 0, 0, 0);
    run(32'h0100, 0, -1, -1, 0, 0, 0);
    run(32'hFFFF_FFF0, 12, -1, -1, 1, 2, 0);
    // Reset while data is flowing
    @(posedge clk); #1;
    cfg_addr = 32'h6000; cfg_len = 24'd40; start = 1'b1; mready_rand = 0; err_beat = -1; last_beat = -1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rvalid;
    end
    check("reach_data", 64'(seen), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs", {busy, done, error, bus.arvalid, bus.rready, bus.m_valid}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = {a[31:12], 12'hF00 | 12'($urandom_range(0, 255))};
      len = $urandom_range(0, 70);
      eb = $urandom_range(0, 3) == 0 ? $urandom_range(0, len) : -1;
      lb = $urandom_range(0, 5) == 0 ? $urandom_range(0, len) : -1;
      run(a, len, eb, lb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), len >= 20 && $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
